// File: rtl/alu_op_sequencer_if.sv
// ALUOp issue interface: request/completion handshake with the main control
// FSM, the code driven to the ALU control decoder, and the ALU flags returned.
interface alu_op_sequencer_if #(
  parameter int OPW = 4
);
  logic           req_valid;
  logic [OPW-1:0] req_op;
  logic           alu_zero;
  logic           alu_lt;
  logic           alu_gt;
  logic [OPW-1:0] alu_op;
  logic           ready;
  logic           done;
  logic           is_branch;
  logic           branch_taken;

  // Control side: main FSM issues requests, ALU supplies flags.
  modport master (
    output req_valid, req_op, alu_zero, alu_lt, alu_gt,
    input  alu_op, ready, done, is_branch, branch_taken
  );

  // Sequencer side.
  modport slave (
    input  req_valid, req_op, alu_zero, alu_lt, alu_gt,
    output alu_op, ready, done, is_branch, branch_taken
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// ALUOp sequencer: accepts one operation from the main FSM, drives the ALU
// control code for the cycles the operation needs (two-step shifts split in
// two sub-codes), resolves branch compares after the flags settle, and
// returns a single done pulse. All outputs are registered.
module alu_op_sequencer #(
  parameter int OPW = 4
) (
  input  logic                clk,
  input  logic                reset,
  alu_op_sequencer_if.slave   sif
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE1 = 3'd1,
    ST_ISSUE2 = 3'd2,
    ST_SETTLE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic [OPW-1:0] OP_NO_OP     = 4'b0000;
  localparam logic [OPW-1:0] OP_SHIFT_L1  = 4'b0101;
  localparam logic [OPW-1:0] OP_SHIFT_L2  = 4'b0110;
  localparam logic [OPW-1:0] OP_SHIFT_RA1 = 4'b1000;
  localparam logic [OPW-1:0] OP_SHIFT_RA2 = 4'b1001;
  localparam logic [OPW-1:0] OP_BEQ       = 4'b1011;
  localparam logic [OPW-1:0] OP_BNE       = 4'b1100;
  localparam logic [OPW-1:0] OP_BLE       = 4'b1101;
  localparam logic [OPW-1:0] OP_BGT       = 4'b1110;

  state_t         r_state;
  logic [OPW-1:0] r_op;
  logic [OPW-1:0] r_alu_op;
  logic           r_ready;
  logic           r_done;
  logic           r_is_branch;
  logic           r_branch_taken;

  // First code issued: two-step shifts start with their first sub-code.
  function automatic logic [OPW-1:0] first_code(input logic [OPW-1:0] op);
    case (op)
      OP_SHIFT_L2:  first_code = OP_SHIFT_L1;
      OP_SHIFT_RA2: first_code = OP_SHIFT_RA1;
      default:      first_code = op;
    endcase
  endfunction

  function automatic logic is_two_step(input logic [OPW-1:0] op);
    is_two_step = (op == OP_SHIFT_L2) || (op == OP_SHIFT_RA2);
  endfunction

  function automatic logic is_branch_op(input logic [OPW-1:0] op);
    is_branch_op = (op >= OP_BEQ) && (op <= OP_BGT);
  endfunction

  // Branch condition from settled flags; non-branch codes never take.
  function automatic logic branch_eval(input logic [OPW-1:0] op,
                                       input logic zero,
                                       input logic lt,
                                       input logic gt);
    case (op)
      OP_BEQ:  branch_eval = zero;
      OP_BNE:  branch_eval = ~zero;
      OP_BLE:  branch_eval = lt | zero;
      OP_BGT:  branch_eval = gt;
      default: branch_eval = 1'b0;
    endcase
  endfunction

  // Sequencer FSM with registered outputs; reset aborts any operation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= ST_IDLE;
      r_op           <= OP_NO_OP;
      r_alu_op       <= OP_NO_OP;
      r_ready        <= 1'b1;
      r_done         <= 1'b0;
      r_is_branch    <= 1'b0;
      r_branch_taken <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done         <= 1'b0;
          r_is_branch    <= 1'b0;
          r_branch_taken <= 1'b0;
          if (sif.req_valid) begin
            r_op     <= sif.req_op;
            r_alu_op <= first_code(sif.req_op);
            r_ready  <= 1'b0;
            r_state  <= ST_ISSUE1;
          end else begin
            r_alu_op <= OP_NO_OP;
            r_ready  <= 1'b1;
            r_state  <= ST_IDLE;
          end
        end
        ST_ISSUE1: begin
          if (is_two_step(r_op)) begin
            r_alu_op <= r_op;
            r_state  <= ST_ISSUE2;
          end else begin
            r_alu_op <= r_alu_op;
            r_state  <= ST_SETTLE;
          end
        end
        ST_ISSUE2: begin
          r_alu_op <= r_alu_op;
          r_state  <= ST_SETTLE;
        end
        ST_SETTLE: begin
          // Decoder output has been stable for this cycle; flags are valid.
          r_alu_op       <= OP_NO_OP;
          r_done         <= 1'b1;
          r_is_branch    <= is_branch_op(r_op);
          r_branch_taken <= branch_eval(r_op, sif.alu_zero, sif.alu_lt, sif.alu_gt);
          r_state        <= ST_DONE;
        end
        ST_DONE: begin
          r_alu_op       <= OP_NO_OP;
          r_done         <= 1'b0;
          r_is_branch    <= 1'b0;
          r_branch_taken <= 1'b0;
          r_ready        <= 1'b1;
          r_state        <= ST_IDLE;
        end
        default: begin
          r_alu_op       <= OP_NO_OP;
          r_done         <= 1'b0;
          r_is_branch    <= 1'b0;
          r_branch_taken <= 1'b0;
          r_ready        <= 1'b1;
          r_state        <= ST_IDLE;
        end
      endcase
    end
  end

  assign sif.alu_op       = r_alu_op;
  assign sif.ready        = r_ready;
  assign sif.done         = r_done;
  assign sif.is_branch    = r_is_branch;
  assign sif.branch_taken = r_branch_taken;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: table of single operations with
// hand-computed code sequences and branch results, plus hand-written reset,
// busy-request and abort sequences. Outputs are sampled on the falling edge.
module tb_alu_op_sequencer;

  logic clk;
  logic reset;

  alu_op_sequencer_if #(.OPW(4)) sif ();

  alu_op_sequencer #(.OPW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .sif   (sif)
  );

  typedef struct {
    logic [3:0] op;
    logic       zero;
    logic       lt;
    logic       gt;
    logic       two;
    logic [3:0] code1;
    logic [3:0] code2;
    logic       isb;
    logic       taken;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Runs one request starting at a falling edge in IDLE; ends at a falling edge in IDLE.
  task automatic run_op(input vec_t v, input string tag);
    sif.req_op    = v.op;
    sif.req_valid = 1'b1;
    sif.alu_zero  = ~v.zero;
    sif.alu_lt    = ~v.lt;
    sif.alu_gt    = ~v.gt;
    check({tag, " ready_idle"}, {3'b000, sif.ready}, 4'b0001);
    @(negedge clk);
    sif.req_valid = 1'b0;
    sif.req_op    = 4'b0011;
    check({tag, " issue1_code"}, sif.alu_op, v.code1);
    check({tag, " issue1_ready"}, {3'b000, sif.ready}, 4'b0000);
    check({tag, " issue1_flags"}, {2'b00, sif.done, sif.is_branch}, 4'b0000);
    if (v.two) begin
      @(negedge clk);
      check({tag, " issue2_code"}, sif.alu_op, v.code2);
    end
    @(negedge clk);
    check({tag, " settle_code"}, sif.alu_op, v.code2);
    check({tag, " settle_done"}, {2'b00, sif.done, sif.branch_taken}, 4'b0000);
    sif.alu_zero = v.zero;
    sif.alu_lt   = v.lt;
    sif.alu_gt   = v.gt;
    @(negedge clk);
    sif.alu_zero = ~v.zero;
    sif.alu_lt   = ~v.lt;
    sif.alu_gt   = ~v.gt;
    check({tag, " done_code"}, sif.alu_op, 4'b0000);
    check({tag, " done_pulse"}, {3'b000, sif.done}, 4'b0001);
    check({tag, " done_ready"}, {3'b000, sif.ready}, 4'b0000);
    check({tag, " is_branch"}, {3'b000, sif.is_branch}, {3'b000, v.isb});
    check({tag, " branch_taken"}, {3'b000, sif.branch_taken}, {3'b000, v.taken});
    @(negedge clk);
    check({tag, " after_ready"}, {3'b000, sif.ready}, 4'b0001);
    check({tag, " after_outs"}, {1'b0, sif.done, sif.is_branch, sif.branch_taken}, 4'b0000);
  endtask

  // Safety net against a stuck simulation.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs [15];
    logic [3:0] busy_code [9];
    logic       busy_done [9];
    vec_t       add_v;

    //          op       z     lt    gt    two   code1    code2    isb   taken
    vecs[0]  = '{4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 4'b0001, 1'b0, 1'b0}; // ADD
    vecs[1]  = '{4'b1001, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1000, 4'b1001, 1'b0, 1'b0}; // SHIFT_RA2
    vecs[2]  = '{4'b0110, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0101, 4'b0110, 1'b0, 1'b0}; // SHIFT_L2
    vecs[3]  = '{4'b1011, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1011, 4'b1011, 1'b1, 1'b1}; // BEQ z=1
    vecs[4]  = '{4'b1100, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1100, 4'b1100, 1'b1, 1'b0}; // BNE z=1
    vecs[5]  = '{4'b1101, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1101, 4'b1101, 1'b1, 1'b1}; // BLE lt=1
    vecs[6]  = '{4'b1110, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1110, 4'b1110, 1'b1, 1'b0}; // BGT gt=0
    vecs[7]  = '{4'b1011, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1011, 4'b1011, 1'b1, 1'b0}; // BEQ z=0
    vecs[8]  = '{4'b1100, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1100, 4'b1100, 1'b1, 1'b1}; // BNE z=0
    vecs[9]  = '{4'b1101, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1101, 4'b1101, 1'b1, 1'b1}; // BLE z=1
    vecs[10] = '{4'b1101, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1101, 4'b1101, 1'b1, 1'b0}; // BLE none
    vecs[11] = '{4'b1110, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1110, 4'b1110, 1'b1, 1'b1}; // BGT gt=1
    vecs[12] = '{4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0}; // NO_OP
    vecs[13] = '{4'b1010, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1010, 4'b1010, 1'b0, 1'b0}; // SLTI
    vecs[14] = '{4'b0101, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0101, 4'b0101, 1'b0, 1'b0}; // SHIFT_L1
    add_v = vecs[0];

    // LUI then one SUB; request held high during LUI.
    busy_code = '{4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
    busy_done = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    reset         = 1'b1;
    sif.req_valid = 1'b0;
    sif.req_op    = 4'b0000;
    sif.alu_zero  = 1'b0;
    sif.alu_lt    = 1'b0;
    sif.alu_gt    = 1'b0;

    // Reset asserted mid-cycle takes effect without a clock edge.
    @(negedge clk);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("rst alu_op", sif.alu_op, 4'b0000);
    check("rst ready", {3'b000, sif.ready}, 4'b0001);
    check("rst outs", {1'b0, sif.done, sif.is_branch, sif.branch_taken}, 4'b0000);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst ready", {3'b000, sif.ready}, 4'b0001);

    for (int i = 0; i < 15; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Busy request: SUB held during LUI is accepted only once, after DONE.
    sif.req_op    = 4'b1111;
    sif.req_valid = 1'b1;
    @(negedge clk);
    sif.req_op = 4'b0010;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge clk);
      check($sformatf("busy code c%0d", i), sif.alu_op, busy_code[i]);
      check($sformatf("busy done c%0d", i), {3'b000, sif.done}, {3'b000, busy_done[i]});
      if (i == 4) sif.req_valid = 1'b0;
    end
    check("busy ready", {3'b000, sif.ready}, 4'b0001);

    // Abort: reset during ISSUE2 of SHIFT_L2.
    sif.req_op    = 4'b0110;
    sif.req_valid = 1'b1;
    @(negedge clk);
    sif.req_valid = 1'b0;
    check("abort issue1", sif.alu_op, 4'b0101);
    @(negedge clk);
    check("abort issue2", sif.alu_op, 4'b0110);
    #2;
    reset = 1'b0;
    #1;
    check("abort alu_op", sif.alu_op, 4'b0000);
    check("abort ready", {3'b000, sif.ready}, 4'b0001);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("abort no_done c%0d", i), {3'b000, sif.done}, 4'b0000);
      check($sformatf("abort idle c%0d", i), {sif.ready, 3'b000}, 4'b1000);
    end
    run_op(add_v, "post_abort_add");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
